router_reg: RTL and testbench
=============================

Name: router_reg

Overview:
- Datapath register stage of the 1x3 router. Sits directly downstream of router_fsm, alongside it.
- Consumes the FSM state strobes and captures header, payload and parity bytes from the input port. Drives the byte stream (dout) toward the output FIFOs.
- Computes running parity and returns parity_done and low_pkt_valid to router_fsm. Flags packet parity errors on err.

Parameters:
WIDTH, 8, byte width of data_in/dout and of all internal byte registers
INVALID_ADDR, 2'b11, header address value treated as invalid; such a header is never latched

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
pkt_valid  input  1  source asserts while header/payload bytes are valid; deasserts on parity byte
data_in  input  WIDTH  packet byte stream; header bits [1:0] = destination address, [7:2] = payload length
fifo_full  input  1  selected output FIFO full
rst_int_reg  input  1  from router_fsm; clears low_pkt_valid
detect_add  input  1  from router_fsm; DECODE_ADDRESS state
lfd_state  input  1  from router_fsm; LOAD_FIRST_DATA state
ld_state  input  1  from router_fsm; LOAD_DATA state
laf_state  input  1  from router_fsm; LOAD_AFTER_FULL state
full_state  input  1  from router_fsm; FIFO_FULL_STATE
parity_done  output  1  packet parity byte captured
low_pkt_valid  output  1  pkt_valid seen low during LOAD_DATA
err  output  1  parity mismatch for the completed packet
dout  output  WIDTH  byte to output FIFO write port

Behaviour:
- Reset (reset=0, async): dout, parity_done, low_pkt_valid, err and all internal registers (hdr, hold, int_par, pkt_par) = 0. Reset overrides every other condition.
- hdr: if detect_add && pkt_valid && data_in[1:0]!=INVALID_ADDR, then hdr <= data_in. Otherwise hdr holds.
- dout update priority (first match wins); dout holds otherwise:
  1. lfd_state: dout <= hdr.
  2. ld_state && pkt_valid && !fifo_full: dout <= data_in.
  3. laf_state: dout <= hold.
- hold: if ld_state && pkt_valid && fifo_full, then hold <= data_in; dout unchanged that cycle. The byte is replayed in LOAD_AFTER_FULL.
- int_par (running XOR):
  - detect_add: int_par <= 0.
  - lfd_state: int_par <= int_par ^ hdr.
  - ld_state && pkt_valid && !full_state: int_par <= int_par ^ data_in. This includes the byte parked in hold.
- pkt_par: if ld_state && !pkt_valid, then pkt_par <= data_in (the parity byte).
- low_pkt_valid:
  - Set: ld_state && !pkt_valid.
  - Clear: rst_int_reg. Clear wins if both are asserted.
  - Holds otherwise.
- parity_done:
  - Clear: detect_add.
  - Set: (ld_state && !fifo_full && !pkt_valid) or (laf_state && low_pkt_valid && !parity_done).
  - Clear has priority over set.
- err:
  - Registered, updated one cycle after parity_done rises: err <= (int_par != pkt_par).
  - Held until next detect_add, which clears it.
  - Never asserted before parity_done.
- Latency: each strobe-driven capture is visible on outputs one clock after the strobe cycle. dout needs no combinational path from data_in.
- Reset mid-packet: all registers zero immediately. The next packet starts clean at detect_add.
- Invalid address header: hdr retains the previous value. router_fsm does not enter lfd_state, so dout is unaffected.
- Back-to-back packets: detect_add clears int_par, parity_done and err in the same cycle the new header is latched.

Test Plan:
- Reset: drive reset=0 mid-operation with data_in=8'hFF -> all outputs and internal registers read 0 on the next sampling edge, with no clock required.
- Good packet: header 8'h05 at detect_add, then lfd, then ld with 8'hA5 (pkt_valid=1), then ld with parity 8'hA0 (pkt_valid=0).
  - dout sequence: 05, A5.
  - low_pkt_valid=1 and parity_done=1 after the parity cycle.
  - err=0 one cycle later.
- Bad parity: same packet with parity byte 8'hA1 -> err=1 one cycle after parity_done rises; err stays 1 until the next detect_add clears it.
- FIFO full mid-payload: ld with 8'h3C and fifo_full=1 -> dout holds previous value. Then laf_state -> dout=3C. int_par includes 3C, so parity byte 05^3C=39 gives err=0.
- Invalid address: detect_add with data_in=8'h07 (addr 11) -> hdr unchanged (previous 8'h05 retained); dout unchanged.
- Priority: rst_int_reg and (ld_state && !pkt_valid) in the same cycle -> low_pkt_valid=0. Also, detect_add while parity_done=1 -> parity_done=0, err=0 next edge.

Source files
------------

// File: rtl/router_reg_if.sv
// router_reg_if: byte-stream and FSM-strobe bundle between router_fsm, the
// input port and router_reg. Rev 1.0.
`default_nettype none

interface router_reg_if #(
  parameter int WIDTH = 8
);
  logic             pkt_valid;
  logic [WIDTH-1:0] data_in;
  logic             fifo_full;
  logic             rst_int_reg;
  logic             detect_add;
  logic             lfd_state;
  logic             ld_state;
  logic             laf_state;
  logic             full_state;
  logic             parity_done;
  logic             low_pkt_valid;
  logic             err;
  logic [WIDTH-1:0] dout;

  modport master (
    output pkt_valid, data_in, fifo_full, rst_int_reg,
    output detect_add, lfd_state, ld_state, laf_state, full_state,
    input  parity_done, low_pkt_valid, err, dout
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, rst_int_reg,
    input  detect_add, lfd_state, ld_state, laf_state, full_state,
    output parity_done, low_pkt_valid, err, dout
  );
endinterface

`default_nettype wire

// File: rtl/router_reg.sv
// router_reg: 1x3 router datapath stage - header/payload/parity capture,
// running parity and packet error flag. Rev 1.0.
`default_nettype none

module router_reg #(
  parameter int         WIDTH        = 8,
  parameter logic [1:0] INVALID_ADDR = 2'b11
) (
  input  logic        clock,
  input  logic        reset,
  router_reg_if.slave bus
);

  logic [WIDTH-1:0] hdr;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] int_par;
  logic [WIDTH-1:0] pkt_par;
  logic [WIDTH-1:0] dout_reg;
  logic             parity_done_reg;
  logic             parity_done_prev;
  logic             low_pkt_valid_reg;
  logic             err_reg;

  logic             payload_take;
  logic             payload_park;
  logic             parity_byte;
  logic             parity_set;

  assign payload_take = bus.ld_state && bus.pkt_valid && !bus.fifo_full;
  assign payload_park = bus.ld_state && bus.pkt_valid && bus.fifo_full;
  assign parity_byte  = bus.ld_state && !bus.pkt_valid;
  // Parity completes directly in LOAD_DATA, or later in LOAD_AFTER_FULL when
  // the parity byte arrived while the FIFO was full.
  assign parity_set   = (parity_byte && !bus.fifo_full) ||
                        (bus.laf_state && low_pkt_valid_reg && !parity_done_reg);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hdr               <= '0;
      hold              <= '0;
      int_par           <= '0;
      pkt_par           <= '0;
      dout_reg          <= '0;
      parity_done_reg   <= 1'b0;
      parity_done_prev  <= 1'b0;
      low_pkt_valid_reg <= 1'b0;
      err_reg           <= 1'b0;
    end else begin
      if (bus.detect_add && bus.pkt_valid && (bus.data_in[1:0] != INVALID_ADDR))
        hdr <= bus.data_in;

      if (bus.lfd_state)
        dout_reg <= hdr;
      else if (payload_take)
        dout_reg <= bus.data_in;
      else if (bus.laf_state)
        dout_reg <= hold;

      if (payload_park)
        hold <= bus.data_in;

      // A parked byte is folded into parity when parked, not when replayed.
      if (bus.detect_add)
        int_par <= '0;
      else if (bus.lfd_state)
        int_par <= int_par ^ hdr;
      else if (bus.ld_state && bus.pkt_valid && !bus.full_state)
        int_par <= int_par ^ bus.data_in;

      if (parity_byte)
        pkt_par <= bus.data_in;

      if (bus.rst_int_reg)
        low_pkt_valid_reg <= 1'b0;
      else if (parity_byte)
        low_pkt_valid_reg <= 1'b1;

      if (bus.detect_add)
        parity_done_reg <= 1'b0;
      else if (parity_set)
        parity_done_reg <= 1'b1;

      parity_done_prev <= parity_done_reg;

      // Compare one cycle after parity_done rises so pkt_par is settled.
      if (bus.detect_add)
        err_reg <= 1'b0;
      else if (parity_done_reg && !parity_done_prev)
        err_reg <= (int_par != pkt_par);
    end
  end

  assign bus.dout          = dout_reg;
  assign bus.parity_done   = parity_done_reg;
  assign bus.low_pkt_valid = low_pkt_valid_reg;
  assign bus.err           = err_reg;

endmodule

`default_nettype wire

// File: tb/tb_router_reg.sv
// tb_router_reg: drives router_fsm-like strobe sequences into router_reg and
// checks every cycle against a packet-level reference model via a scoreboard.
`default_nettype none

module tb_router_reg;

  logic clock;
  logic reset;

  router_reg_if #(.WIDTH(8)) bus ();

  router_reg #(.WIDTH(8), .INVALID_ADDR(2'b11)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] dout;
    logic       pd;
    logic       low;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: packet-level view (bytes accepted so far in a queue)
  logic [7:0] m_hdr, m_hold, m_dout, m_pkt_par;
  logic       m_low, m_pd, m_err, m_pend;
  logic [7:0] pkt_bytes[$];
  logic [7:0] pay [0:15];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %02h, expected %02h", name, $time, act, req);
    end
  endtask

  function automatic logic [7:0] bytes_xor();
    logic [7:0] x = 8'h00;
    foreach (pkt_bytes[i]) x ^= pkt_bytes[i];
    return x;
  endfunction

  task automatic model_reset();
    m_hdr = 0; m_hold = 0; m_dout = 0; m_pkt_par = 0;
    m_low = 0; m_pd = 0; m_err = 0; m_pend = 0;
    pkt_bytes.delete();
  endtask

  task automatic model_edge(input logic det, lfd, ld, laf, fst, rsti, pv, ff,
                            input logic [7:0] din);
    logic [7:0] n_hdr, n_dout, n_hold, n_par;
    logic       n_low, n_pd, n_err;
    n_err = m_err;
    if (det)         n_err = 1'b0;
    else if (m_pend) n_err = (bytes_xor() != m_pkt_par);
    n_hdr = (det && pv && din[1:0] != 2'b11) ? din : m_hdr;
    if (lfd)                n_dout = m_hdr;
    else if (ld && pv && !ff) n_dout = din;
    else if (laf)           n_dout = m_hold;
    else                    n_dout = m_dout;
    n_hold = (ld && pv && ff) ? din : m_hold;
    n_par  = (ld && !pv) ? din : m_pkt_par;
    n_low  = rsti ? 1'b0 : ((ld && !pv) ? 1'b1 : m_low);
    if (det) n_pd = 1'b0;
    else if ((ld && !ff && !pv) || (laf && m_low && !m_pd)) n_pd = 1'b1;
    else n_pd = m_pd;
    if (det)                  pkt_bytes.delete();
    else if (lfd)             pkt_bytes.push_back(m_hdr);
    else if (ld && pv && !fst) pkt_bytes.push_back(din);
    m_pend = n_pd && !m_pd;
    m_hdr = n_hdr; m_dout = n_dout; m_hold = n_hold; m_pkt_par = n_par;
    m_low = n_low; m_pd = n_pd; m_err = n_err;
  endtask

  task automatic step(input logic det, lfd, ld, laf, fst, rsti, pv, ff,
                      input logic [7:0] din);
    exp_t e;
    bus.detect_add = det; bus.lfd_state = lfd; bus.ld_state = ld;
    bus.laf_state = laf; bus.full_state = fst; bus.rst_int_reg = rsti;
    bus.pkt_valid = pv; bus.fifo_full = ff; bus.data_in = din;
    @(posedge clock);
    #1;
    model_edge(det, lfd, ld, laf, fst, rsti, pv, ff, din);
    e.dout = m_dout; e.pd = m_pd; e.low = m_low; e.err = m_err;
    sb.push_back(e);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic do_reset();
    @(negedge clock);
    #2;
    bus.data_in = 8'hFF;
    reset = 1'b0;
    #1;
    check("rst_dout", bus.dout, 8'h00);
    check("rst_parity_done", {7'd0, bus.parity_done}, 8'h00);
    check("rst_low_pkt_valid", {7'd0, bus.low_pkt_valid}, 8'h00);
    check("rst_err", {7'd0, bus.err}, 8'h00);
    model_reset();
    bus.detect_add = 0; bus.lfd_state = 0; bus.ld_state = 0; bus.laf_state = 0;
    bus.full_state = 0; bus.rst_int_reg = 0; bus.pkt_valid = 0; bus.fifo_full = 0;
    @(posedge clock);
    #3;
    reset = 1'b1;
  endtask

  // full_idx == len parks the parity byte; full_idx > len means no stall.
  task automatic send_packet(input logic [7:0] hdr, input int len, input int full_idx,
                             input logic bad, input int rst_at);
    logic [7:0] par;
    step(1, 0, 0, 0, 0, 0, 1, 0, hdr);
    if (hdr[1:0] == 2'b11) begin
      idle();
      return;
    end
    step(0, 1, 0, 0, 0, 0, 1, 0, pay[0]);
    par = hdr;
    for (int i = 0; i < len; i++) begin
      if (i == rst_at) begin
        do_reset();
        return;
      end
      par ^= pay[i];
      step(0, 0, 1, 0, 0, 0, 1, (i == full_idx), pay[i]);
      if (i == full_idx) begin
        step(0, 0, 0, 0, 1, 0, 1, 1, pay[i]);
        step(0, 0, 0, 0, 1, 0, 1, 0, pay[i]);
        step(0, 0, 0, 1, 0, 0, 1, 0, pay[i]);
      end
    end
    if (bad) par ^= 8'h01;
    step(0, 0, 1, 0, 0, 0, 0, (full_idx == len), par);
    if (full_idx == len) begin
      step(0, 0, 0, 0, 1, 0, 0, 1, par);
      step(0, 0, 0, 0, 1, 0, 0, 0, par);
      step(0, 0, 0, 1, 0, 0, 0, 0, par);
    end
    step(0, 0, 0, 0, 0, 1, 0, 0, 8'h00);
    idle();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("dout", bus.dout, e.dout);
        check("parity_done", {7'd0, bus.parity_done}, {7'd0, e.pd});
        check("low_pkt_valid", {7'd0, bus.low_pkt_valid}, {7'd0, e.low});
        check("err", {7'd0, bus.err}, {7'd0, e.err});
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [7:0] h;
    int len, fidx, rst_at;
    logic bad;
    model_reset();
    reset = 1'b0;
    bus.detect_add = 0; bus.lfd_state = 0; bus.ld_state = 0; bus.laf_state = 0;
    bus.full_state = 0; bus.rst_int_reg = 0; bus.pkt_valid = 0; bus.fifo_full = 0;
    bus.data_in = 8'hFF;
    #1;
    check("por_dout", bus.dout, 8'h00);
    check("por_err", {7'd0, bus.err}, 8'h00);
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b1;

    // Good, bad-parity and FIFO-full packets
    pay[0] = 8'hA5;
    send_packet(8'h05, 1, 99, 1'b0, 99);
    send_packet(8'h05, 1, 99, 1'b1, 99);
    pay[0] = 8'h3C;
    send_packet(8'h05, 1, 0, 1'b0, 99);
    // Invalid address keeps previous header; an lfd afterwards replays it
    step(1, 0, 0, 0, 0, 0, 1, 0, 8'h07);
    step(0, 1, 0, 0, 0, 0, 1, 0, 8'h11);
    step(0, 0, 1, 0, 0, 0, 0, 0, 8'h05);
    // rst_int_reg beats a low_pkt_valid set in the same cycle
    step(0, 0, 1, 0, 0, 1, 0, 0, 8'h22);
    idle();
    // Reset mid-packet, then a clean packet
    pay[0] = 8'h5A; pay[1] = 8'hC3;
    send_packet(8'h06, 2, 99, 1'b0, 1);
    send_packet(8'h06, 2, 1, 1'b1, 99);

    for (int p = 0; p < 60; p++) begin
      h      = 8'($urandom_range(0, 255));
      len    = $urandom_range(1, 6);
      fidx   = $urandom_range(0, len + 2);
      bad    = ($urandom_range(0, 2) == 0);
      rst_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, len - 1) : 99;
      for (int i = 0; i < len; i++) pay[i] = 8'($urandom_range(0, 255));
      send_packet(h, len, fidx, bad, rst_at);
    end

    repeat (4) @(negedge clock);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
